// File: rtl/host_axil_pkg.sv
// host_axil_pkg
// Shared types and constants for the host-to-AXI4-Lite control bridge.
//   state_t       : bridge FSM states
//   resp_entry_t  : one response-queue entry {data, code, is_write, timeout}
//   RESP_OKAY / RESP_SLVERR : AXI response codes used by the bridge
package host_axil_pkg;

    // Entry data is sized for the widest supported AXI data bus; narrower
    // builds zero-extend on push and take the low bits on pop.
    localparam int RESP_DATA_MAX = 64;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP
    } state_t;

    typedef struct packed {
        logic [RESP_DATA_MAX-1:0] data;
        logic [1:0]               code;
        logic                     is_write;
        logic                     timeout;
    } resp_entry_t;

endpackage

// File: rtl/host_resp_fifo.sv
// host_resp_fifo
// Small synchronous FIFO holding host response entries.
// Ports:
//   i_clk, i_rst_n          : clock, asynchronous active-low reset
//   i_push_valid/o_push_ready/i_push_data : write side
//   o_pop_valid/i_pop_ready/o_pop_data    : read side (head entry)
//   o_count                 : number of stored entries
// A push and a pop in the same cycle are both accepted even when full.
module host_resp_fifo #(
    parameter int  DEPTH   = 2,
    parameter type entry_t = logic [7:0]
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_push_valid,
    output logic                         o_push_ready,
    input  entry_t                       i_push_data,
    output logic                         o_pop_valid,
    input  logic                         i_pop_ready,
    output entry_t                       o_pop_data,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    entry_t            r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_valid;

    logic              w_push;
    logic              w_pop;
    logic [CNT_W-1:0]  w_count_next;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_pop        = r_valid && i_pop_ready;
    assign o_push_ready = (r_count < CNT_W'(DEPTH)) || w_pop;
    assign w_push       = i_push_valid && o_push_ready;

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_count <= w_count_next;
            r_valid <= (w_count_next != '0);
        end
    end

    // Storage carries data only; occupancy is tracked by the control registers.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    // Head is forced to zero when empty so the outputs are clean during reset.
    assign o_pop_valid = r_valid;
    assign o_pop_data  = r_valid ? r_mem[r_rd_ptr] : '0;
    assign o_count     = r_count;

endmodule

// File: rtl/host_axil_bridge.sv
// host_axil_bridge
// Converts host register read/write requests into AXI4-Lite transactions on
// an accelerator's s_axi_control port, one transaction at a time.
// Ports:
//   clock, reset            : clock, asynchronous active-low reset
//   host_req_*              : host request (valid/opcode/addr/value) and deq pulse
//   host_resp_*             : response queue head (valid/ready/bits/code/is_write/timeout)
//   s_axi_control_AW/W/B/AR/R* : AXI4-Lite manager channels
module host_axil_bridge
    import host_axil_pkg::*;
#(
    parameter int HOST_ADDR_BITS = 8,
    parameter int HOST_DATA_BITS = 32,
    parameter int AXI_ADDR_BITS  = 6,
    parameter int AXI_DATA_BITS  = 32,
    parameter int AXI_STRB_BITS  = AXI_DATA_BITS / 8,
    parameter int RESP_DEPTH     = 2,
    parameter int WRITE_RESP_EN  = 0,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      host_req_valid,
    input  logic                      host_req_opcode,
    input  logic [HOST_ADDR_BITS-1:0] host_req_addr,
    input  logic [HOST_DATA_BITS-1:0] host_req_value,
    output logic                      host_req_deq,
    output logic                      host_resp_valid,
    input  logic                      host_resp_ready,
    output logic [HOST_DATA_BITS-1:0] host_resp_bits,
    output logic [1:0]                host_resp_code,
    output logic                      host_resp_is_write,
    output logic                      host_resp_timeout,
    output logic                      s_axi_control_AWVALID,
    input  logic                      s_axi_control_AWREADY,
    output logic [AXI_ADDR_BITS-1:0]  s_axi_control_AWADDR,
    output logic                      s_axi_control_WVALID,
    input  logic                      s_axi_control_WREADY,
    output logic [AXI_DATA_BITS-1:0]  s_axi_control_WDATA,
    output logic [AXI_STRB_BITS-1:0]  s_axi_control_WSTRB,
    input  logic                      s_axi_control_BVALID,
    output logic                      s_axi_control_BREADY,
    input  logic [1:0]                s_axi_control_BRESP,
    output logic                      s_axi_control_ARVALID,
    input  logic                      s_axi_control_ARREADY,
    output logic [AXI_ADDR_BITS-1:0]  s_axi_control_ARADDR,
    input  logic                      s_axi_control_RVALID,
    output logic                      s_axi_control_RREADY,
    input  logic [AXI_DATA_BITS-1:0]  s_axi_control_RDATA,
    input  logic [1:0]                s_axi_control_RRESP
);

    localparam int TW    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int CNT_W = $clog2(RESP_DEPTH + 1);
    localparam logic [TW-1:0] TO_VAL = TW'(TIMEOUT_CYCLES);

    state_t                    r_state;
    state_t                    w_state_next;
    logic [AXI_ADDR_BITS-1:0]  r_addr;
    logic [HOST_DATA_BITS-1:0] r_wdata;
    logic                      r_opcode;
    logic                      r_aw_done;
    logic                      r_w_done;
    logic [TW-1:0]             r_tcnt;

    logic                      w_capture;
    logic                      w_timeout;
    logic                      w_slot_free;
    logic                      w_pop;
    logic                      w_arvalid, w_rready, w_awvalid, w_wvalid, w_bready;
    logic                      w_aw_fire, w_w_fire;
    logic                      w_push_req;
    logic                      w_push_ready;
    resp_entry_t               w_push_entry;
    resp_entry_t               w_head;
    logic [CNT_W-1:0]          w_count;
    logic                      w_unused;

    // A pop in the same cycle frees a slot, so a full queue being drained
    // does not stall the next capture.
    assign w_pop       = host_resp_valid && host_resp_ready;
    assign w_slot_free = (w_count < CNT_W'(RESP_DEPTH)) || w_pop;
    assign w_timeout   = (TIMEOUT_CYCLES != 0) && (r_state != IDLE) && (r_tcnt == TO_VAL);
    assign w_aw_fire   = w_awvalid && s_axi_control_AWREADY;
    assign w_w_fire    = w_wvalid && s_axi_control_WREADY;

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_arvalid    = 1'b0;
        w_rready     = 1'b0;
        w_awvalid    = 1'b0;
        w_wvalid     = 1'b0;
        w_bready     = 1'b0;
        w_push_req   = 1'b0;
        w_push_entry = '0;
        if (w_timeout) begin
            // Abort: every AXI valid/ready stays low this cycle.
            w_push_req            = 1'b1;
            w_push_entry.code     = RESP_SLVERR;
            w_push_entry.is_write = r_opcode;
            w_push_entry.timeout  = 1'b1;
            w_state_next          = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    // Gated by reset so deq stays low while reset is held.
                    if (reset && host_req_valid && w_slot_free) begin
                        w_capture    = 1'b1;
                        w_state_next = host_req_opcode ? WR_REQ : RD_ADDR;
                    end
                end
                RD_ADDR: begin
                    w_arvalid = 1'b1;
                    if (s_axi_control_ARREADY) w_state_next = RD_DATA;
                end
                RD_DATA: begin
                    w_rready = 1'b1;
                    if (s_axi_control_RVALID) begin
                        w_push_req        = 1'b1;
                        w_push_entry.data = RESP_DATA_MAX'(s_axi_control_RDATA);
                        w_push_entry.code = s_axi_control_RRESP;
                        w_state_next      = IDLE;
                    end
                end
                WR_REQ: begin
                    w_awvalid = !r_aw_done;
                    w_wvalid  = !r_w_done;
                    if ((r_aw_done || (w_awvalid && s_axi_control_AWREADY)) &&
                        (r_w_done  || (w_wvalid  && s_axi_control_WREADY)))
                        w_state_next = WR_RESP;
                end
                WR_RESP: begin
                    w_bready = 1'b1;
                    if (s_axi_control_BVALID) begin
                        w_state_next = IDLE;
                        if (WRITE_RESP_EN != 0) begin
                            w_push_req            = 1'b1;
                            w_push_entry.code     = s_axi_control_BRESP;
                            w_push_entry.is_write = 1'b1;
                        end
                    end
                end
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_opcode  <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_tcnt    <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_capture) begin
                r_opcode  <= host_req_opcode;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
                r_tcnt    <= '0;
            end else begin
                if (r_state != IDLE) r_tcnt <= r_tcnt + 1'b1;
                if (w_aw_fire) r_aw_done <= 1'b1;
                if (w_w_fire)  r_w_done  <= 1'b1;
            end
        end
    end

    // Captured address/data are only observed while a valid is high.
    always_ff @(posedge clock) begin
        if (w_capture) begin
            r_addr  <= host_req_addr[AXI_ADDR_BITS-1:0];
            r_wdata <= host_req_value;
        end
    end

    host_resp_fifo #(
        .DEPTH   (RESP_DEPTH),
        .entry_t (resp_entry_t)
    ) u_resp_fifo (
        .i_clk        (clock),
        .i_rst_n      (reset),
        .i_push_valid (w_push_req),
        .o_push_ready (w_push_ready),
        .i_push_data  (w_push_entry),
        .o_pop_valid  (host_resp_valid),
        .i_pop_ready  (host_resp_ready),
        .o_pop_data   (w_head),
        .o_count      (w_count)
    );

    assign host_req_deq          = w_capture;
    assign host_resp_bits        = w_head.data[HOST_DATA_BITS-1:0];
    assign host_resp_code        = w_head.code;
    assign host_resp_is_write    = w_head.is_write;
    assign host_resp_timeout     = w_head.timeout;

    assign s_axi_control_ARVALID = w_arvalid;
    assign s_axi_control_ARADDR  = w_arvalid ? r_addr : '0;
    assign s_axi_control_RREADY  = w_rready;
    assign s_axi_control_AWVALID = w_awvalid;
    assign s_axi_control_AWADDR  = w_awvalid ? r_addr : '0;
    assign s_axi_control_WVALID  = w_wvalid;
    assign s_axi_control_WDATA   = w_wvalid ? r_wdata : '0;
    assign s_axi_control_WSTRB   = {AXI_STRB_BITS{w_wvalid}};
    assign s_axi_control_BREADY  = w_bready;

    // Sink for bits that only matter in wider builds (upper entry data,
    // host address bits above the AXI range, BRESP when acks are off) and
    // for the queue's push-ready, which the free-slot rule makes redundant.
    assign w_unused = ^{w_head.data, host_req_addr, s_axi_control_BRESP, w_push_ready};

endmodule

// File: tb/tb_host_axil_bridge.sv
// tb_host_axil_bridge
// Directed bench for host_axil_bridge. Two instances share all inputs:
// u_dut_a has write acknowledgements enabled, u_dut_b has them disabled.
module tb_host_axil_bridge;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_opcode;
    logic [7:0]  req_addr;
    logic [31:0] req_value;
    logic        resp_ready;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    logic        a_deq, a_rv, a_isw, a_to, a_awvalid, a_wvalid, a_bready, a_arvalid, a_rready;
    logic [31:0] a_bits, a_wdata;
    logic [1:0]  a_code;
    logic [5:0]  a_awaddr, a_araddr;
    logic [3:0]  a_wstrb;
    logic        b_deq, b_rv, b_isw, b_to, b_awvalid, b_wvalid, b_bready, b_arvalid, b_rready;
    logic [31:0] b_bits, b_wdata;
    logic [1:0]  b_code;
    logic [5:0]  b_awaddr, b_araddr;
    logic [3:0]  b_wstrb;

    logic [90:0] a_all, b_all;
    logic [35:0] a_ent, b_ent;
    assign a_all = {a_deq, a_rv, a_bits, a_code, a_isw, a_to, a_awvalid, a_awaddr, a_wvalid,
                    a_wdata, a_wstrb, a_bready, a_arvalid, a_araddr, a_rready};
    assign b_all = {b_deq, b_rv, b_bits, b_code, b_isw, b_to, b_awvalid, b_awaddr, b_wvalid,
                    b_wdata, b_wstrb, b_bready, b_arvalid, b_araddr, b_rready};
    assign a_ent = {a_bits, a_code, a_isw, a_to};
    assign b_ent = {b_bits, b_code, b_isw, b_to};

    int n_run  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    host_axil_bridge #(
        .HOST_ADDR_BITS(8), .HOST_DATA_BITS(32), .AXI_ADDR_BITS(6), .AXI_DATA_BITS(32),
        .AXI_STRB_BITS(4), .RESP_DEPTH(2), .WRITE_RESP_EN(1), .TIMEOUT_CYCLES(16)
    ) u_dut_a (
        .clock(clock), .reset(reset),
        .host_req_valid(req_valid), .host_req_opcode(req_opcode),
        .host_req_addr(req_addr), .host_req_value(req_value), .host_req_deq(a_deq),
        .host_resp_valid(a_rv), .host_resp_ready(resp_ready), .host_resp_bits(a_bits),
        .host_resp_code(a_code), .host_resp_is_write(a_isw), .host_resp_timeout(a_to),
        .s_axi_control_AWVALID(a_awvalid), .s_axi_control_AWREADY(awready),
        .s_axi_control_AWADDR(a_awaddr), .s_axi_control_WVALID(a_wvalid),
        .s_axi_control_WREADY(wready), .s_axi_control_WDATA(a_wdata),
        .s_axi_control_WSTRB(a_wstrb), .s_axi_control_BVALID(bvalid),
        .s_axi_control_BREADY(a_bready), .s_axi_control_BRESP(bresp),
        .s_axi_control_ARVALID(a_arvalid), .s_axi_control_ARREADY(arready),
        .s_axi_control_ARADDR(a_araddr), .s_axi_control_RVALID(rvalid),
        .s_axi_control_RREADY(a_rready), .s_axi_control_RDATA(rdata),
        .s_axi_control_RRESP(rresp)
    );

    host_axil_bridge #(
        .HOST_ADDR_BITS(8), .HOST_DATA_BITS(32), .AXI_ADDR_BITS(6), .AXI_DATA_BITS(32),
        .AXI_STRB_BITS(4), .RESP_DEPTH(2), .WRITE_RESP_EN(0), .TIMEOUT_CYCLES(16)
    ) u_dut_b (
        .clock(clock), .reset(reset),
        .host_req_valid(req_valid), .host_req_opcode(req_opcode),
        .host_req_addr(req_addr), .host_req_value(req_value), .host_req_deq(b_deq),
        .host_resp_valid(b_rv), .host_resp_ready(resp_ready), .host_resp_bits(b_bits),
        .host_resp_code(b_code), .host_resp_is_write(b_isw), .host_resp_timeout(b_to),
        .s_axi_control_AWVALID(b_awvalid), .s_axi_control_AWREADY(awready),
        .s_axi_control_AWADDR(b_awaddr), .s_axi_control_WVALID(b_wvalid),
        .s_axi_control_WREADY(wready), .s_axi_control_WDATA(b_wdata),
        .s_axi_control_WSTRB(b_wstrb), .s_axi_control_BVALID(bvalid),
        .s_axi_control_BREADY(b_bready), .s_axi_control_BRESP(bresp),
        .s_axi_control_ARVALID(b_arvalid), .s_axi_control_ARREADY(arready),
        .s_axi_control_ARADDR(b_araddr), .s_axi_control_RVALID(rvalid),
        .s_axi_control_RREADY(b_rready), .s_axi_control_RDATA(rdata),
        .s_axi_control_RRESP(rresp)
    );

    // Zero-wait read: capture, AR handshake, R handshake, then idle.
    task automatic host_read(input logic [7:0] a, input logic [31:0] d, input logic [1:0] r);
        @(negedge clock); req_valid = 1'b1; req_opcode = 1'b0; req_addr = a;
        @(negedge clock); req_valid = 1'b0; arready = 1'b1;
        @(negedge clock); arready = 1'b0; rvalid = 1'b1; rdata = d; rresp = r;
        @(negedge clock); rvalid = 1'b0;
    endtask

    // Zero-wait write with AW and W accepted in the same cycle.
    task automatic host_write(input logic [7:0] a, input logic [31:0] v, input logic [1:0] r);
        @(negedge clock); req_valid = 1'b1; req_opcode = 1'b1; req_addr = a; req_value = v;
        @(negedge clock); req_valid = 1'b0; awready = 1'b1; wready = 1'b1;
        @(negedge clock); awready = 1'b0; wready = 1'b0; bvalid = 1'b1; bresp = r;
        @(negedge clock); bvalid = 1'b0;
    endtask

    task automatic drain();
        resp_ready = 1'b1;
        repeat (4) @(negedge clock);
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; req_valid = 1'b1; req_opcode = 1'b0; req_addr = 8'h08;
        repeat (2) @(negedge clock);
        #1;
        n_run++; if (a_all !== '0) begin n_fail++; $display("FAIL reset_outputs_a got=%h exp=0", a_all); end
        n_run++; if (b_all !== '0) begin n_fail++; $display("FAIL reset_outputs_b got=%h exp=0", b_all); end
        req_valid = 1'b0;
        @(negedge clock); reset = 1'b1; #1;
        n_run++; if (a_rv !== 1'b0) begin n_fail++; $display("FAIL reset_release_rv got=%b exp=0", a_rv); end
    endtask

    task automatic test_read();
        @(negedge clock); req_valid = 1'b1; req_opcode = 1'b0; req_addr = 8'h08; #1;
        n_run++; if (a_deq !== 1'b1) begin n_fail++; $display("FAIL rd_deq got=%b exp=1", a_deq); end
        @(negedge clock); req_valid = 1'b0; arready = 1'b1; #1;
        n_run++; if (a_deq !== 1'b0) begin n_fail++; $display("FAIL rd_deq_pulse got=%b exp=0", a_deq); end
        n_run++; if ({a_arvalid, a_araddr} !== {1'b1, 6'h08}) begin n_fail++; $display("FAIL rd_ar got=%b/%h exp=1/08", a_arvalid, a_araddr); end
        @(negedge clock); arready = 1'b0; rvalid = 1'b1; rdata = 32'hDEADBEEF; rresp = 2'b00; #1;
        n_run++; if ({a_arvalid, a_rready, a_rv} !== 3'b010) begin n_fail++; $display("FAIL rd_rphase got=%b exp=010", {a_arvalid, a_rready, a_rv}); end
        @(negedge clock); rvalid = 1'b0; #1;
        n_run++; if (a_rv !== 1'b1) begin n_fail++; $display("FAIL rd_latency_rv got=%b exp=1", a_rv); end
        n_run++; if (a_ent !== {32'hDEADBEEF, 2'b00, 1'b0, 1'b0}) begin n_fail++; $display("FAIL rd_entry got=%h exp=%h", a_ent, {32'hDEADBEEF, 4'h0}); end
        resp_ready = 1'b1;
        @(negedge clock); resp_ready = 1'b0; #1;
        n_run++; if (a_rv !== 1'b0) begin n_fail++; $display("FAIL rd_single_entry got=%b exp=0", a_rv); end
    endtask

    task automatic test_write_split();
        @(negedge clock); req_valid = 1'b1; req_opcode = 1'b1; req_addr = 8'h00; req_value = 32'h1; #1;
        n_run++; if (a_deq !== 1'b1) begin n_fail++; $display("FAIL wr_deq got=%b exp=1", a_deq); end
        @(negedge clock); req_valid = 1'b0; wready = 1'b1; #1;
        n_run++; if ({a_awvalid, a_wvalid, a_wdata, a_wstrb} !== {2'b11, 32'h1, 4'hF}) begin n_fail++; $display("FAIL wr_issue got=%b%b/%h/%h exp=11/00000001/f", a_awvalid, a_wvalid, a_wdata, a_wstrb); end
        @(negedge clock); wready = 1'b0; #1;
        n_run++; if ({a_awvalid, a_wvalid} !== 2'b10) begin n_fail++; $display("FAIL wr_w_drop got=%b exp=10", {a_awvalid, a_wvalid}); end
        @(negedge clock); #1;
        n_run++; if ({a_awvalid, a_wvalid} !== 2'b10) begin n_fail++; $display("FAIL wr_aw_hold got=%b exp=10", {a_awvalid, a_wvalid}); end
        @(negedge clock); awready = 1'b1; #1;
        n_run++; if ({a_awvalid, a_awaddr, a_bready} !== {1'b1, 6'h00, 1'b0}) begin n_fail++; $display("FAIL wr_aw got=%b/%h/%b exp=1/00/0", a_awvalid, a_awaddr, a_bready); end
        @(negedge clock); awready = 1'b0; bvalid = 1'b1; bresp = 2'b10; #1;
        n_run++; if ({a_awvalid, a_bready} !== 2'b01) begin n_fail++; $display("FAIL wr_bphase got=%b exp=01", {a_awvalid, a_bready}); end
        @(negedge clock); bvalid = 1'b0; #1;
        n_run++; if ({a_rv, a_ent} !== {1'b1, 32'h0, 2'b10, 1'b1, 1'b0}) begin n_fail++; $display("FAIL wr_ack_entry got=%b/%h exp=1/%h", a_rv, a_ent, {32'h0, 4'h6}); end
        n_run++; if (b_rv !== 1'b0) begin n_fail++; $display("FAIL wr_no_ack_b got=%b exp=0", b_rv); end
        drain();
    endtask

    task automatic test_queue_full();
        resp_ready = 1'b0;
        host_read(8'h10, 32'h11111111, 2'b00);
        host_read(8'h14, 32'h22222222, 2'b00);
        @(negedge clock); req_valid = 1'b1; req_opcode = 1'b0; req_addr = 8'h18; #1;
        n_run++; if (a_deq !== 1'b0) begin n_fail++; $display("FAIL full_no_deq got=%b exp=0", a_deq); end
        @(negedge clock); #1;
        n_run++; if ({a_deq, a_arvalid, a_rv, a_bits} !== {3'b001, 32'h11111111}) begin n_fail++; $display("FAIL full_pending got=%b/%h exp=001/11111111", {a_deq, a_arvalid, a_rv}, a_bits); end
        @(negedge clock); resp_ready = 1'b1; #1;
        n_run++; if ({a_deq, a_bits} !== {1'b1, 32'h11111111}) begin n_fail++; $display("FAIL full_pop1 got=%b/%h exp=1/11111111", a_deq, a_bits); end
        @(negedge clock); req_valid = 1'b0; arready = 1'b1; #1;
        n_run++; if ({a_arvalid, a_rv, a_bits} !== {2'b11, 32'h22222222}) begin n_fail++; $display("FAIL full_pop2 got=%b/%h exp=11/22222222", {a_arvalid, a_rv}, a_bits); end
        @(negedge clock); arready = 1'b0; rvalid = 1'b1; rdata = 32'h33333333; rresp = 2'b00; #1;
        n_run++; if (a_rv !== 1'b0) begin n_fail++; $display("FAIL full_emptied got=%b exp=0", a_rv); end
        @(negedge clock); rvalid = 1'b0; #1;
        n_run++; if ({a_rv, a_bits} !== {1'b1, 32'h33333333}) begin n_fail++; $display("FAIL full_third got=%b/%h exp=1/33333333", a_rv, a_bits); end
        drain();
    endtask

    task automatic test_timeout();
        int n_hi;
        n_hi = 0;
        @(negedge clock); req_valid = 1'b1; req_opcode = 1'b0; req_addr = 8'h20; #1;
        n_run++; if (a_deq !== 1'b1) begin n_fail++; $display("FAIL to_deq got=%b exp=1", a_deq); end
        for (int i = 0; i < 40; i++) begin
            @(negedge clock); req_valid = 1'b0; #1;
            if (a_arvalid === 1'b1) n_hi++;
            else break;
        end
        n_run++; if (n_hi !== 16) begin n_fail++; $display("FAIL to_arvalid_cycles got=%0d exp=16", n_hi); end
        @(negedge clock); rvalid = 1'b1; rdata = 32'h00000BAD; #1;
        n_run++; if ({a_rv, a_ent} !== {1'b1, 32'h0, 2'b10, 1'b0, 1'b1}) begin n_fail++; $display("FAIL to_entry got=%b/%h exp=1/%h", a_rv, a_ent, {32'h0, 4'h9}); end
        n_run++; if (a_rready !== 1'b0) begin n_fail++; $display("FAIL to_idle_rready got=%b exp=0", a_rready); end
        @(negedge clock); rvalid = 1'b0; resp_ready = 1'b1;
        @(negedge clock); resp_ready = 1'b0; #1;
        n_run++; if (a_rv !== 1'b0) begin n_fail++; $display("FAIL to_late_ignored got=%b exp=0", a_rv); end
        @(negedge clock); req_valid = 1'b1; req_opcode = 1'b0; req_addr = 8'h24; #1;
        n_run++; if (a_deq !== 1'b1) begin n_fail++; $display("FAIL to_next_deq got=%b exp=1", a_deq); end
        @(negedge clock); req_valid = 1'b0; arready = 1'b1;
        @(negedge clock); arready = 1'b0; rvalid = 1'b1; rdata = 32'h44444444; rresp = 2'b10;
        @(negedge clock); rvalid = 1'b0; #1;
        n_run++; if ({a_rv, a_ent} !== {1'b1, 32'h44444444, 2'b10, 2'b00}) begin n_fail++; $display("FAIL to_next_entry got=%b/%h exp=1/%h", a_rv, a_ent, {32'h44444444, 4'h8}); end
        drain();
    endtask

    task automatic test_reset_mid();
        resp_ready = 1'b0;
        host_read(8'h04, 32'h55555555, 2'b00);
        @(negedge clock); req_valid = 1'b1; req_opcode = 1'b1; req_addr = 8'h08; req_value = 32'h66; #1;
        n_run++; if (a_deq !== 1'b1) begin n_fail++; $display("FAIL rm_deq got=%b exp=1", a_deq); end
        @(negedge clock); req_valid = 1'b0; awready = 1'b1; wready = 1'b1;
        @(negedge clock); awready = 1'b0; wready = 1'b0; #1;
        n_run++; if ({a_bready, a_rv, a_awvalid, a_wvalid} !== 4'b1100) begin n_fail++; $display("FAIL rm_wr_resp got=%b exp=1100", {a_bready, a_rv, a_awvalid, a_wvalid}); end
        #1; reset = 1'b0; req_valid = 1'b1; #1;
        n_run++; if (a_all !== '0) begin n_fail++; $display("FAIL rm_outputs_a got=%h exp=0", a_all); end
        n_run++; if (b_all !== '0) begin n_fail++; $display("FAIL rm_outputs_b got=%h exp=0", b_all); end
        @(negedge clock); reset = 1'b1; req_valid = 1'b0; #1;
        n_run++; if ({a_rv, a_bready} !== 2'b00) begin n_fail++; $display("FAIL rm_after got=%b exp=00", {a_rv, a_bready}); end
        @(negedge clock); req_valid = 1'b1; req_opcode = 1'b0; req_addr = 8'h0C; #1;
        n_run++; if (a_deq !== 1'b1) begin n_fail++; $display("FAIL rm_idle_deq got=%b exp=1", a_deq); end
        @(negedge clock); req_valid = 1'b0; arready = 1'b1;
        @(negedge clock); arready = 1'b0; rvalid = 1'b1; rdata = 32'h77777777; rresp = 2'b00;
        @(negedge clock); rvalid = 1'b0; #1;
        n_run++; if ({a_rv, a_bits} !== {1'b1, 32'h77777777}) begin n_fail++; $display("FAIL rm_head got=%b/%h exp=1/77777777", a_rv, a_bits); end
        drain();
    endtask

    task automatic test_no_write_ack();
        resp_ready = 1'b0;
        host_write(8'h04, 32'hA5, 2'b00);
        host_read(8'h0C, 32'h12345678, 2'b00);
        @(negedge clock); #1;
        n_run++; if ({b_rv, b_ent} !== {1'b1, 32'h12345678, 4'h0}) begin n_fail++; $display("FAIL nack_b_head got=%b/%h exp=1/%h", b_rv, b_ent, {32'h12345678, 4'h0}); end
        n_run++; if ({a_rv, a_isw} !== 2'b11) begin n_fail++; $display("FAIL nack_a_head got=%b exp=11", {a_rv, a_isw}); end
        resp_ready = 1'b1;
        @(negedge clock); resp_ready = 1'b0; #1;
        n_run++; if (b_rv !== 1'b0) begin n_fail++; $display("FAIL nack_b_only_read got=%b exp=0", b_rv); end
        n_run++; if ({a_rv, a_bits, a_isw} !== {1'b1, 32'h12345678, 1'b0}) begin n_fail++; $display("FAIL nack_a_second got=%b/%h/%b exp=1/12345678/0", a_rv, a_bits, a_isw); end
        drain();
    endtask

    initial begin
        req_valid = 1'b0; req_opcode = 1'b0; req_addr = '0; req_value = '0;
        resp_ready = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0;
        test_reset();
        test_read();
        test_write_split();
        test_queue_full();
        test_timeout();
        test_reset_mid();
        test_no_write_ack();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench did not finish");
    end

endmodule
